// File: rtl/axi_bridge_ip_rx_pkg.sv
// RX beat-assembly types and helpers shared by the RX deserializer files.
// Latency: n/a (package).
// Backpressure: n/a (package).
package axi_bridge_ip_rx_pkg;

    import axi_bridge_ip_tx_pkg::MAX_KEEP_W;

    localparam int KEEP_CNT_W = $clog2(MAX_KEEP_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DROP  = 2'd2
    } rx_asm_state_e;

    // Low-contiguous byte mask covering bytes [0, cnt+nbytes).
    function automatic logic [MAX_KEEP_W-1:0] keep_from_count(
        input logic [KEEP_CNT_W-1:0] cnt,
        input logic [KEEP_CNT_W-1:0] nbytes
    );
        logic [KEEP_CNT_W:0]   total;
        logic [MAX_KEEP_W-1:0] mask;
        total = {1'b0, cnt} + {1'b0, nbytes};
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = ((KEEP_CNT_W + 1)'(i) < total);
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_bridge_ip_tx_pkg.sv
// Shared TX-side constants used by both the TX and RX beat paths.
// Latency: n/a (package).
// Backpressure: n/a (package).
package axi_bridge_ip_tx_pkg;

    // Widest TKEEP any bridge build supports (512-bit beats).
    localparam int MAX_KEEP_W = 64;

endpackage

// File: rtl/axi_bridge_ip_rx_deser_out_reg.sv
// Single-entry holding register between beat assembly and the RX FIFO.
// Latency: entry loaded in cycle N is offered to the FIFO from cycle N+1.
// Backpressure: holds the entry stable while fifo_full_i; flush_i drops it without a push.
//
// Ports: ld_vld_i/ld_dat_i load a new entry (may coincide with a push);
//        out_vld_o = entry pending; fifo_push_o/fifo_wdata_o drive the FIFO write.
module axi_bridge_ip_rx_deser_out_reg #(
    parameter int ENTRY_W = 305
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               ld_vld_i,
    input  logic [ENTRY_W-1:0] ld_dat_i,
    input  logic               fifo_full_i,
    output logic               out_vld_o,
    output logic               fifo_push_o,
    output logic [ENTRY_W-1:0] fifo_wdata_o
);

    logic               vld_q;
    logic [ENTRY_W-1:0] dat_q;

    assign out_vld_o    = vld_q;
    assign fifo_push_o  = vld_q && !fifo_full_i && !flush_i;
    assign fifo_wdata_o = dat_q;

    // A load in the same cycle as a push keeps the entry valid with the new beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (ld_vld_i) begin
            vld_q <= 1'b1;
            dat_q <= ld_dat_i;
        end else if (fifo_push_o) begin
            vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_bridge_ip_rx_deser_beat_assemble.sv
// Packs IF_W link segments into DATA_W AXI-Stream beats {last,user,keep,data} for the RX FIFO.
// Latency: eob segment accepted in cycle N -> fifo_push_o earliest in cycle N+1; 1 segment/cycle sustained.
// Backpressure: seg_ready_o drops while an output beat is pending and fifo_full_i, or when disabled/flushing.
//
// Ports: seg_* segment input (valid/ready), fifo_full_i/fifo_push_o/fifo_wdata_o FIFO write side,
//        enable_i gates acceptance, flush_i drops partial and pending beats, err_ovf_o one-cycle
//        error pulse (registered), busy_o = partial beat held or output pending.
// Optional: AXI_BRIDGE_IP_RX_DESER_STATS_EN adds saturating stat_beats_o / stat_drops_o counters.
module axi_bridge_ip_rx_deser_beat_assemble
    import axi_bridge_ip_rx_pkg::*;
    import axi_bridge_ip_tx_pkg::MAX_KEEP_W;
#(
    parameter  int DATA_W  = 256,
    parameter  int IF_W    = 64,
    parameter  int TUSER_W = 16,
    localparam int BPB     = DATA_W / 8,
    localparam int BPS     = IF_W / 8,
    localparam int SB_W    = $clog2(BPS + 1),
    localparam int ENTRY_W = DATA_W + BPB + TUSER_W + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic               seg_valid_i,
    output logic               seg_ready_o,
    input  logic [IF_W-1:0]    seg_data_i,
    input  logic [SB_W-1:0]    seg_nbytes_i,
    input  logic               seg_eob_i,
    input  logic [TUSER_W-1:0] seg_user_i,
    input  logic               seg_last_i,
    input  logic               fifo_full_i,
    output logic               fifo_push_o,
    output logic [ENTRY_W-1:0] fifo_wdata_o,
    output logic               err_ovf_o,
    output logic               busy_o
`ifdef AXI_BRIDGE_IP_RX_DESER_STATS_EN
    ,
    output logic [31:0]        stat_beats_o,
    output logic [15:0]        stat_drops_o
`endif
);

    localparam int MAXSEG = (BPB + BPS - 1) / BPS;
    localparam int CNT_W  = $clog2(BPB + 1);
    localparam int SEG_W  = $clog2(MAXSEG + 2);

    if (DATA_W % 8 != 0) begin : g_chk_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (IF_W % 8 != 0) begin : g_chk_if_w
        $error("IF_W must be a multiple of 8");
    end
    if (IF_W > DATA_W) begin : g_chk_if_le_data
        $error("IF_W must not exceed DATA_W");
    end
    if (BPB > MAX_KEEP_W) begin : g_chk_keep_w
        $error("DATA_W/8 exceeds MAX_KEEP_W");
    end

    rx_asm_state_e      state_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [SEG_W-1:0]   seg_cnt_q;
    logic [DATA_W-1:0]  asm_data_q;
    logic [TUSER_W-1:0] user_q;
    logic               last_q;
    logic               err_q;
    logic               out_vld;

    logic               seg_acc;
    logic [CNT_W-1:0]   off;
    logic [CNT_W:0]     sum;
    logic [SEG_W-1:0]   seg_num;
    logic               seg_err;
    logic               commit;
    logic [MAX_KEEP_W-1:0] keep_all;
    logic [MAX_KEEP_W-1:0] keep_old;
    logic [BPB-1:0]     keep_new;
    logic [BPB-1:0]     wr_bytes;
    logic [DATA_W-1:0]  seg_shift;
    logic [DATA_W-1:0]  wr_mask_bits;
    logic [DATA_W-1:0]  keep_bits;
    logic [DATA_W-1:0]  merged;
    logic [TUSER_W-1:0] cur_user;
    logic               cur_last;
    logic [ENTRY_W-1:0] commit_entry;
    logic               unused_keep;

    assign seg_ready_o = enable_i && !flush_i && (!out_vld || !fifo_full_i);
    assign seg_acc     = seg_valid_i && seg_ready_o;

    // First segment of a beat always lands at byte 0, whatever byte_cnt_q holds.
    assign off     = (state_q == S_IDLE) ? '0 : byte_cnt_q;
    assign sum     = {1'b0, off} + (CNT_W + 1)'(seg_nbytes_i);
    assign seg_num = (state_q == S_IDLE) ? SEG_W'(1) : seg_cnt_q + SEG_W'(1);

    assign seg_err = (seg_nbytes_i == '0)
                  || (seg_nbytes_i > SB_W'(BPS))
                  || (sum > (CNT_W + 1)'(BPB))
                  || (seg_num > SEG_W'(MAXSEG));

    // Bytes written by this segment are [off, off+nbytes).
    assign keep_all    = keep_from_count(KEEP_CNT_W'(off), KEEP_CNT_W'(seg_nbytes_i));
    assign keep_old    = keep_from_count(KEEP_CNT_W'(off), '0);
    assign keep_new    = keep_all[BPB-1:0];
    assign wr_bytes    = keep_all[BPB-1:0] & ~keep_old[BPB-1:0];
    assign unused_keep = &{1'b0, keep_all, keep_old};

    assign seg_shift = DATA_W'(seg_data_i) << {off, 3'b000};

    always_comb begin
        wr_mask_bits = '0;
        keep_bits    = '0;
        for (int b = 0; b < BPB; b++) begin
            wr_mask_bits[8*b +: 8] = {8{wr_bytes[b]}};
            keep_bits[8*b +: 8]    = {8{keep_new[b]}};
        end
    end

    // Stale bytes above the fill level are masked off at commit.
    assign merged = (asm_data_q & ~wr_mask_bits) | (seg_shift & wr_mask_bits);

    assign commit   = seg_acc && !seg_err && seg_eob_i && (state_q != S_DROP);
    assign cur_user = (state_q == S_IDLE) ? seg_user_i : user_q;
    assign cur_last = (state_q == S_IDLE) ? seg_last_i : last_q;
    assign commit_entry = {cur_last, cur_user, keep_new, merged & keep_bits};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            seg_cnt_q  <= '0;
            asm_data_q <= '0;
            user_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (flush_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            seg_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= seg_acc && seg_err && (state_q != S_DROP);
            if (seg_acc) begin
                unique case (state_q)
                    S_IDLE, S_ACCUM: begin
                        if (seg_err) begin
                            state_q    <= seg_eob_i ? S_IDLE : S_DROP;
                            byte_cnt_q <= '0;
                            seg_cnt_q  <= '0;
                        end else if (seg_eob_i) begin
                            state_q    <= S_IDLE;
                            byte_cnt_q <= '0;
                            seg_cnt_q  <= '0;
                        end else begin
                            state_q    <= S_ACCUM;
                            byte_cnt_q <= sum[CNT_W-1:0];
                            seg_cnt_q  <= seg_num;
                            asm_data_q <= merged;
                            if (state_q == S_IDLE) begin
                                user_q <= seg_user_i;
                                last_q <= seg_last_i;
                            end
                        end
                    end
                    S_DROP: begin
                        if (seg_eob_i) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign err_ovf_o = err_q;
    assign busy_o    = (state_q != S_IDLE) || out_vld;

    axi_bridge_ip_rx_deser_out_reg #(
        .ENTRY_W (ENTRY_W)
    ) u_out_reg (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .ld_vld_i     (commit),
        .ld_dat_i     (commit_entry),
        .fifo_full_i  (fifo_full_i),
        .out_vld_o    (out_vld),
        .fifo_push_o  (fifo_push_o),
        .fifo_wdata_o (fifo_wdata_o)
    );

`ifdef AXI_BRIDGE_IP_RX_DESER_STATS_EN
    // Saturating; deliberately untouched by flush_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_beats_o <= '0;
            stat_drops_o <= '0;
        end else begin
            if (fifo_push_o && (stat_beats_o != '1)) begin
                stat_beats_o <= stat_beats_o + 32'd1;
            end
            if (err_q && (stat_drops_o != '1)) begin
                stat_drops_o <= stat_drops_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_bridge_ip_rx_deser_beat_assemble.sv
// Self-checking bench for the RX beat assembler with a scoreboard of expected FIFO entries.
// Latency: n/a (bench).
// Backpressure: exercises fifo_full_i, enable_i and flush_i stalls.
module tb_axi_bridge_ip_rx_deser_beat_assemble;

    localparam int DATA_W  = 256;
    localparam int IF_W    = 64;
    localparam int TUSER_W = 16;
    localparam int SB_W    = 4;
    localparam int ENTRY_W = 305;

    logic               clk_i;
    logic               rst_ni;
    logic               enable_i;
    logic               flush_i;
    logic               seg_valid_i;
    logic               seg_ready_o;
    logic [IF_W-1:0]    seg_data_i;
    logic [SB_W-1:0]    seg_nbytes_i;
    logic               seg_eob_i;
    logic [TUSER_W-1:0] seg_user_i;
    logic               seg_last_i;
    logic               fifo_full_i;
    logic               fifo_push_o;
    logic [ENTRY_W-1:0] fifo_wdata_o;
    logic               err_ovf_o;
    logic               busy_o;
`ifdef AXI_BRIDGE_IP_RX_DESER_STATS_EN
    logic [31:0]        stat_beats_o;
    logic [15:0]        stat_drops_o;
`endif

    axi_bridge_ip_rx_deser_beat_assemble #(
        .DATA_W  (DATA_W),
        .IF_W    (IF_W),
        .TUSER_W (TUSER_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .flush_i      (flush_i),
        .seg_valid_i  (seg_valid_i),
        .seg_ready_o  (seg_ready_o),
        .seg_data_i   (seg_data_i),
        .seg_nbytes_i (seg_nbytes_i),
        .seg_eob_i    (seg_eob_i),
        .seg_user_i   (seg_user_i),
        .seg_last_i   (seg_last_i),
        .fifo_full_i  (fifo_full_i),
        .fifo_push_o  (fifo_push_o),
        .fifo_wdata_o (fifo_wdata_o),
        .err_ovf_o    (err_ovf_o),
        .busy_o       (busy_o)
`ifdef AXI_BRIDGE_IP_RX_DESER_STATS_EN
        ,
        .stat_beats_o (stat_beats_o),
        .stat_drops_o (stat_drops_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [ENTRY_W-1:0] exp_q[$];
    int n_vec     = 0;
    int n_bad     = 0;
    int err_seen  = 0;
    int err_exp   = 0;
    int exp_beats = 0;
    int stalls    = 0;
    bit mon_en    = 1'b0;

    // Beat model
    bit                 m_first = 1'b1;
    bit                 m_drop  = 1'b0;
    int                 m_cnt   = 0;
    logic [DATA_W-1:0]  m_data;
    logic [TUSER_W-1:0] m_user;
    logic               m_last;
    logic [TUSER_W-1:0] beat_user;
    logic               beat_last;

    task automatic chk(input string tag, input logic [ENTRY_W-1:0] got, input logic [ENTRY_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-low-phase of the clock.
    always begin
        @(negedge clk_i);
        #2;
        if (mon_en) begin
            if (fifo_push_o) begin
                if (exp_q.size() == 0) chk("push_vs_queue", fifo_push_o, 1'b0);
                else                   chk("beat", fifo_wdata_o, exp_q.pop_front());
            end
            if (err_ovf_o) err_seen++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drive one segment; later segments carry inverted user/last so that
    // sampling on the first segment only is observable.
    task automatic send_seg(input int nb, input bit eob, input bit bad);
        logic [IF_W-1:0] d;
        logic [31:0]     k;
        int              w;
        d = {$urandom, $urandom};
        @(negedge clk_i);
        seg_valid_i  = 1'b1;
        seg_data_i   = d;
        seg_nbytes_i = SB_W'(nb);
        seg_eob_i    = eob;
        seg_user_i   = m_first ? beat_user : ~beat_user;
        seg_last_i   = m_first ? beat_last : ~beat_last;
        #1;
        w = 0;
        while (!seg_ready_o && w < 200) begin
            @(negedge clk_i);
            #1;
            w++;
            stalls++;
        end
        if (w >= 200) begin
            chk("ready_timeout", seg_ready_o, 1'b1);
            seg_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        seg_valid_i = 1'b0;
        if (bad) begin
            err_exp++;
            m_first = 1'b1;
            m_drop  = !eob;
        end else if (m_drop) begin
            if (eob) begin
                m_drop  = 1'b0;
                m_first = 1'b1;
            end
        end else begin
            if (m_first) begin
                m_user  = beat_user;
                m_last  = beat_last;
                m_cnt   = 0;
                m_data  = '0;
                m_first = 1'b0;
            end
            for (int i = 0; i < nb; i++) m_data[8*(m_cnt+i) +: 8] = d[8*i +: 8];
            m_cnt += nb;
            if (eob) begin
                for (int i = 0; i < 32; i++) k[i] = (i < m_cnt);
                exp_q.push_back({m_last, m_user, k, m_data});
                exp_beats++;
                m_first = 1'b1;
            end
        end
    endtask

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; flush_i = 1'b0; seg_valid_i = 1'b0;
        seg_data_i = '0; seg_nbytes_i = '0; seg_eob_i = 1'b0; seg_user_i = '0;
        seg_last_i = 1'b0; fifo_full_i = 1'b0; beat_user = '0; beat_last = 1'b0;
        #3;
        chk("rst_push", fifo_push_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_ovf_o, 1'b0);
        chk("rst_ready", seg_ready_o, 1'b0);
        chk("rst_wdata", fifo_wdata_o, '0);
        idle(2);
        rst_ni = 1'b1; enable_i = 1'b1;
        #1;
        chk("ready_after_rst", seg_ready_o, 1'b1);
        mon_en = 1'b1;

        // Async reset mid-beat discards the partial beat at once.
        beat_user = 16'h1111; beat_last = 1'b0;
        send_seg(8, 0, 0);
        send_seg(8, 0, 0);
        chk("busy_partial", busy_o, 1'b1);
        #2; rst_ni = 1'b0;
        #1; chk("busy_async_rst", busy_o, 1'b0);
        m_first = 1'b1;
        @(negedge clk_i); rst_ni = 1'b1;

        // Full 32-byte beat in four segments.
        beat_user = 16'hA5A5; beat_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_seg(8, i == 3, 0);
            if (i == 2) chk("t1_no_early_push", fifo_push_o, 1'b0);
        end
        chk("t1_push_lat", fifo_push_o, 1'b1);
        chk("t1_keep", fifo_wdata_o[287:256], 32'hFFFF_FFFF);
        chk("t1_last", fifo_wdata_o[304], 1'b1);

        // Partial beat 8+8+5 bytes.
        beat_user = 16'h0F0F; beat_last = 1'b0;
        send_seg(8, 0, 0); send_seg(8, 0, 0); send_seg(5, 1, 0);
        chk("t2_keep", fifo_wdata_o[287:256], 32'h001F_FFFF);
        chk("t2_tail_zero", fifo_wdata_o[255:168], '0);
        chk("t2_err", err_ovf_o, 1'b0);

        // FIFO full holds the pending beat.
        idle(2);
        fifo_full_i = 1'b1;
        beat_user = 16'h3C3C; beat_last = 1'b1;
        send_seg(8, 0, 0); send_seg(4, 1, 0);
        chk("t3_push_full", fifo_push_o, 1'b0);
        chk("t3_ready_full", seg_ready_o, 1'b0);
        chk("t3_busy", busy_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            chk("t3_hold", fifo_wdata_o, exp_q[0]);
        end
        @(negedge clk_i); fifo_full_i = 1'b0;
        #1;
        chk("t3_push_release", fifo_push_o, 1'b1);
        chk("t3_ready_release", seg_ready_o, 1'b1);

        // Five 8-byte segments: overflow on the fifth, then a clean beat.
        idle(1);
        beat_user = 16'h5555; beat_last = 1'b0;
        for (int i = 0; i < 4; i++) send_seg(8, 0, 0);
        send_seg(8, 1, 1);
        chk("t4_err_pulse", err_ovf_o, 1'b1);
        @(posedge clk_i); #1;
        chk("t4_err_clear", err_ovf_o, 1'b0);
        chk("t4_no_push", fifo_push_o, 1'b0);
        beat_user = 16'h6666; beat_last = 1'b1;
        send_seg(8, 0, 0); send_seg(3, 1, 0);
        chk("t4_next_keep", fifo_wdata_o[287:256], 32'h0000_07FF);

        // Zero-byte, oversize and too-many-segment errors.
        beat_user = 16'h7777; beat_last = 1'b0;
        send_seg(0, 1, 1);
        send_seg(9, 1, 1);
        for (int i = 0; i < 4; i++) send_seg(1, 0, 0);
        send_seg(1, 1, 1);
        // Exactly full without eob, then one more byte: error and drop to eob.
        for (int i = 0; i < 4; i++) send_seg(8, 0, 0);
        send_seg(1, 0, 1);
        chk("drop_busy", busy_o, 1'b1);
        send_seg(8, 1, 0);
        beat_user = 16'h8888; beat_last = 1'b1;
        send_seg(8, 0, 0); send_seg(8, 0, 0); send_seg(8, 1, 0);

        // Back-to-back single-segment beats.
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            beat_user = TUSER_W'(16'h9000 + i);
            send_seg(8, 1, 0);
        end
        chk("b2b_stalls", stalls, 0);

        // enable_i low retains the partial beat.
        beat_user = 16'hAAAA; beat_last = 1'b0;
        send_seg(8, 0, 0);
        @(negedge clk_i); enable_i = 1'b0;
        #1; chk("dis_ready", seg_ready_o, 1'b0);
        idle(3);
        #1; chk("dis_busy", busy_o, 1'b1);
        enable_i = 1'b1;
        send_seg(6, 1, 0);

        // Flush a partial beat.
        idle(2);
        beat_user = 16'hBBBB;
        send_seg(8, 0, 0); send_seg(8, 0, 0);
        @(negedge clk_i); flush_i = 1'b1;
        #1; chk("flush_ready", seg_ready_o, 1'b0);
        @(negedge clk_i); flush_i = 1'b0;
        #1; chk("flush_busy_a", busy_o, 1'b0);
        m_first = 1'b1;

        // Flush a pending beat while the FIFO frees up in the same cycle.
        fifo_full_i = 1'b1;
        send_seg(4, 1, 0);
        @(negedge clk_i); flush_i = 1'b1; fifo_full_i = 1'b0;
        #1; chk("flush_no_push", fifo_push_o, 1'b0);
        void'(exp_q.pop_back());
        exp_beats--;
        @(negedge clk_i); flush_i = 1'b0;
        #1;
        chk("flush_busy_b", busy_o, 1'b0);
        chk("flush_after_push", fifo_push_o, 1'b0);
        beat_user = 16'hCCCC; beat_last = 1'b1;
        send_seg(3, 1, 0);
        chk("post_flush_keep", fifo_wdata_o[287:256], 32'h0000_0007);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
        idle(2);
        chk("queue_drained", exp_q.size(), 0);
        chk("err_count", err_seen, err_exp);
`ifdef AXI_BRIDGE_IP_RX_DESER_STATS_EN
        chk("stat_beats", stat_beats_o, exp_beats);
        chk("stat_drops", stat_drops_o, err_exp);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
